// File: rtl/updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// updown_counter_pkg
// Shared helpers for the up/down counter slice.
//   prescale_width(div) : width of a phase counter that counts 0..div-1,
//                         never less than 1 bit so the vector stays legal.
// -----------------------------------------------------------------------------
package updown_counter_pkg;

    function automatic int unsigned prescale_width(input int unsigned div);
        if (div <= 1)
            return 1;
        else
            return $clog2(div);
    endfunction

endpackage

// File: rtl/updown_counter_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Produces a one-cycle step strobe on every DIV-th enabled cycle.
//   i_clk     : clock, rising edge
//   i_reset   : asynchronous, active-high reset (phase -> 0)
//   i_restart : synchronous phase restart (phase -> 0)
//   i_en      : enable; the phase only advances while high, holds otherwise
//   o_tick    : i_en && phase == DIV-1
// With DIV=1 there is no phase to keep and o_tick is simply i_en.
// -----------------------------------------------------------------------------
module tick_prescaler
    import updown_counter_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned PW = prescale_width(DIV);

    generate
        if (DIV <= 1) begin : g_bypass
            // Clock, reset and restart have no effect on a divide-by-one.
            logic unused_inputs;
            assign unused_inputs = ^{i_clk, i_reset, i_restart};
            assign o_tick        = i_en;
        end else begin : g_divide
            localparam logic [PW-1:0] LAST = PW'(DIV - 1);

            logic [PW-1:0] phase;

            assign o_tick = i_en && (phase == LAST);

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    phase <= '0;
                end else if (i_restart) begin
                    phase <= '0;
                end else if (i_en) begin
                    phase <= o_tick ? '0 : phase + PW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
// Up/down counter over the inclusive range 0..i_limit with synchronous
// clear/load, an enable prescaler and a wrap-or-saturate end-of-range mode.
//   i_clk      : clock, rising edge
//   i_reset    : asynchronous, active-high reset
//   i_clear    : synchronous clear (highest priority)
//   i_load     : synchronous load of min(i_load_val, i_limit)
//   i_load_val : load value
//   i_limit    : inclusive upper bound, may change at any time
//   i_en       : count enable, gates the prescaler
//   i_up       : 1 counts up, 0 counts down
//   o_count    : registered count
//   o_tc       : terminal count, combinational from o_count/i_up/i_limit
//   o_wrap     : registered one-cycle pulse after a wrapping step
// -----------------------------------------------------------------------------
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_en,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_wrap
);

    logic             tick;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    tick_prescaler #(
        .DIV (PRESCALE)
    ) u_prescaler (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_restart (i_clear | i_load),
        .i_en      (i_en),
        .o_tick    (tick)
    );

    assign o_tc = i_up ? (o_count >= i_limit) : (o_count == '0);

    always_comb begin
        count_nxt = o_count;
        wrap_nxt  = 1'b0;
        if (i_clear) begin
            count_nxt = '0;
        end else if (i_load) begin
            count_nxt = (i_load_val > i_limit) ? i_limit : i_load_val;
        end else if (tick) begin
            if (i_up) begin
                // End of range is tested before incrementing, so the +1
                // can never overflow WIDTH bits.
                if (o_count < i_limit) begin
                    count_nxt = o_count + WIDTH'(1);
                end else if (SATURATE) begin
                    count_nxt = i_limit;
                end else begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (o_count == '0) begin
                    if (!SATURATE) begin
                        count_nxt = i_limit;
                        wrap_nxt  = 1'b1;
                    end
                end else if (o_count > i_limit) begin
                    // A limit lowered under the count pulls it back into range.
                    count_nxt = i_limit;
                end else begin
                    count_nxt = o_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_count <= '0;
            o_wrap  <= 1'b0;
        end else begin
            o_count <= count_nxt;
            o_wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
module tb_updown_counter;

    localparam int N = 3;
    // Instance 0: PRESCALE=1 wrap, 1: PRESCALE=4 wrap, 2: PRESCALE=1 saturate
    localparam int DIV [N] = '{1, 4, 1};
    localparam bit SAT [N] = '{1'b0, 1'b0, 1'b1};

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_load = 1'b0;
    logic [7:0] i_load_val = '0;
    logic [7:0] i_limit = 8'd255;
    logic       i_en = 1'b1;
    logic       i_up = 1'b1;

    logic [7:0] cnt0, cnt1, cnt2;
    logic       tc0, tc1, tc2, wr0, wr1, wr2;
    logic [7:0] cnt [N];
    logic       tc  [N];
    logic       wrap[N];

    assign cnt[0] = cnt0; assign cnt[1] = cnt1; assign cnt[2] = cnt2;
    assign tc[0]  = tc0;  assign tc[1]  = tc1;  assign tc[2]  = tc2;
    assign wrap[0] = wr0; assign wrap[1] = wr1; assign wrap[2] = wr2;

    int m_cnt [N];
    int m_en_seen [N];
    bit m_wrap [N];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    updown_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(1'b0)) u_d0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_load(i_load),
        .i_load_val(i_load_val), .i_limit(i_limit), .i_en(i_en), .i_up(i_up),
        .o_count(cnt0), .o_tc(tc0), .o_wrap(wr0));

    updown_counter #(.WIDTH(8), .PRESCALE(4), .SATURATE(1'b0)) u_d1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_load(i_load),
        .i_load_val(i_load_val), .i_limit(i_limit), .i_en(i_en), .i_up(i_up),
        .o_count(cnt1), .o_tc(tc1), .o_wrap(wr1));

    updown_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(1'b1)) u_d2 (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_load(i_load),
        .i_load_val(i_load_val), .i_limit(i_limit), .i_en(i_en), .i_up(i_up),
        .o_count(cnt2), .o_tc(tc2), .o_wrap(wr2));

    // Reference model: counts enabled cycles since the last restart and
    // steps whenever that count reaches a multiple of the divide ratio.
    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0; m_en_seen[k] = 0; m_wrap[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int lim;
        int lv;
        lim = int'(i_limit);
        lv  = int'(i_load_val);
        for (int k = 0; k < N; k++) begin
            bit stepping;
            stepping  = 1'b0;
            m_wrap[k] = 1'b0;
            if (i_clear) begin
                m_cnt[k] = 0; m_en_seen[k] = 0;
            end else if (i_load) begin
                m_cnt[k] = (lv < lim) ? lv : lim; m_en_seen[k] = 0;
            end else if (i_en) begin
                m_en_seen[k] = m_en_seen[k] + 1;
                stepping = (m_en_seen[k] % DIV[k]) == 0;
            end
            if (stepping) begin
                if (i_up) begin
                    if (m_cnt[k] + 1 <= lim) m_cnt[k] = m_cnt[k] + 1;
                    else if (SAT[k])         m_cnt[k] = lim;
                    else begin m_cnt[k] = 0; m_wrap[k] = 1'b1; end
                end else begin
                    if (m_cnt[k] == 0) begin
                        if (!SAT[k]) begin m_cnt[k] = lim; m_wrap[k] = 1'b1; end
                    end else begin
                        m_cnt[k] = (m_cnt[k] > lim) ? lim : m_cnt[k] - 1;
                    end
                end
            end
        end
    endtask

    function automatic bit exp_tc(input int k);
        return i_up ? (m_cnt[k] >= int'(i_limit)) : (m_cnt[k] == 0);
    endfunction

    task automatic clk_step();
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        i_limit = 8'd255; i_en = 1'b1; i_up = 1'b1;
        #17 i_reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (cnt[k] !== 8'd0) begin n_fail++; $display("FAIL reset_count d%0d got %0d want 0", k, cnt[k]); end
            n_tests++;
            if (wrap[k] !== 1'b0) begin n_fail++; $display("FAIL reset_wrap d%0d got %0b want 0", k, wrap[k]); end
            n_tests++;
            if (tc[k] !== 1'b0) begin n_fail++; $display("FAIL reset_tc d%0d got %0b want 0", k, tc[k]); end
        end
        #10 i_reset = 1'b0;
    endtask

    task automatic test_up_wrap();
        for (int c = 0; c < 262; c++) begin
            clk_step();
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if (cnt[k] !== 8'(m_cnt[k])) begin n_fail++; $display("FAIL up_wrap_count d%0d got %0d want %0d", k, cnt[k], m_cnt[k]); end
                n_tests++;
                if (tc[k] !== exp_tc(k) || wrap[k] !== m_wrap[k]) begin
                    n_fail++; $display("FAIL up_wrap_flags d%0d got tc=%0b wrap=%0b want tc=%0b wrap=%0b", k, tc[k], wrap[k], exp_tc(k), m_wrap[k]);
                end
            end
        end
    endtask

    task automatic test_modulo_down();
        i_limit = 8'd9; i_clear = 1'b1;
        clk_step();
        i_clear = 1'b0;
        for (int c = 0; c < 38; c++) begin
            if (c == 23) i_up = 1'b0;
            clk_step();
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if (cnt[k] !== 8'(m_cnt[k])) begin n_fail++; $display("FAIL modulo_count d%0d got %0d want %0d", k, cnt[k], m_cnt[k]); end
                n_tests++;
                if (tc[k] !== exp_tc(k) || wrap[k] !== m_wrap[k]) begin
                    n_fail++; $display("FAIL modulo_flags d%0d got tc=%0b wrap=%0b want tc=%0b wrap=%0b", k, tc[k], wrap[k], exp_tc(k), m_wrap[k]);
                end
            end
        end
        i_up = 1'b1;
    endtask

    task automatic test_saturate();
        i_limit = 8'd5; i_clear = 1'b1;
        clk_step();
        i_clear = 1'b0;
        for (int c = 0; c < 22; c++) begin
            if (c == 12) begin i_load = 1'b1; i_load_val = 8'd2; end
            if (c == 13) begin i_load = 1'b0; i_up = 1'b0; end
            clk_step();
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if (cnt[k] !== 8'(m_cnt[k])) begin n_fail++; $display("FAIL sat_count d%0d got %0d want %0d", k, cnt[k], m_cnt[k]); end
                n_tests++;
                if (tc[k] !== exp_tc(k) || wrap[k] !== m_wrap[k]) begin
                    n_fail++; $display("FAIL sat_flags d%0d got tc=%0b wrap=%0b want tc=%0b wrap=%0b", k, tc[k], wrap[k], exp_tc(k), m_wrap[k]);
                end
            end
        end
        n_tests++;
        if (cnt2 !== 8'd0) begin n_fail++; $display("FAIL sat_down_floor got %0d want 0", cnt2); end
        i_up = 1'b1;
    endtask

    task automatic test_prescale_enable();
        i_limit = 8'd20; i_clear = 1'b1;
        clk_step();
        i_clear = 1'b0;
        for (int c = 0; c < 26; c++) begin
            i_en = !(c >= 6 && c < 9);
            if (c == 15) begin i_load = 1'b1; i_load_val = 8'd3; end
            if (c == 16) i_load = 1'b0;
            clk_step();
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if (cnt[k] !== 8'(m_cnt[k])) begin n_fail++; $display("FAIL prescale_count d%0d got %0d want %0d", k, cnt[k], m_cnt[k]); end
            end
        end
        i_en = 1'b1;
    endtask

    task automatic test_priority();
        i_limit = 8'd20; i_load = 1'b1; i_load_val = 8'd50;
        clk_step();
        n_tests++;
        if (cnt0 !== 8'd20) begin n_fail++; $display("FAIL load_clamp got %0d want 20", cnt0); end
        i_clear = 1'b1;
        clk_step();
        n_tests++;
        if (cnt0 !== 8'd0) begin n_fail++; $display("FAIL clear_over_load got %0d want 0", cnt0); end
        i_clear = 1'b0; i_load_val = 8'd15;
        clk_step();
        i_load = 1'b0; i_limit = 8'd10;
        clk_step();
        n_tests++;
        if (cnt0 !== 8'd0 || wr0 !== 1'b1) begin n_fail++; $display("FAIL lower_limit_up got %0d/%0b want 0/1", cnt0, wr0); end
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (cnt[k] !== 8'(m_cnt[k]) || wrap[k] !== m_wrap[k]) begin
                n_fail++; $display("FAIL priority_model d%0d got %0d/%0b want %0d/%0b", k, cnt[k], wrap[k], m_cnt[k], m_wrap[k]);
            end
        end
        i_up = 1'b0;
        clk_step();
        n_tests++;
        if (cnt0 !== 8'd10) begin n_fail++; $display("FAIL lower_limit_down got %0d want 10", cnt0); end
        n_tests++;
        if (cnt2 !== 8'(m_cnt[2])) begin n_fail++; $display("FAIL clamp_down_sat got %0d want %0d", cnt2, m_cnt[2]); end
        i_up = 1'b1;
    endtask

    task automatic test_mid_reset();
        i_limit = 8'd255; i_en = 1'b1; i_up = 1'b1; i_clear = 1'b1;
        clk_step();
        i_clear = 1'b0;
        for (int c = 0; c < 30; c++) clk_step();
        n_tests++;
        if (cnt1 !== 8'd7) begin n_fail++; $display("FAIL mid_reset_setup got %0d want 7", cnt1); end
        #2 i_reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (cnt[k] !== 8'd0) begin n_fail++; $display("FAIL mid_reset_count d%0d got %0d want 0", k, cnt[k]); end
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            clk_step();
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if (cnt[k] !== 8'(m_cnt[k])) begin n_fail++; $display("FAIL after_reset_count d%0d got %0d want %0d", k, cnt[k], m_cnt[k]); end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            i_clear = ($urandom_range(0, 99) < 3);
            i_load  = ($urandom_range(0, 99) < 5);
            i_load_val = 8'($urandom);
            i_en = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 10) i_up = ~i_up;
            if ($urandom_range(0, 99) < 4) begin
                case ($urandom_range(0, 3))
                    0: i_limit = 8'd0;
                    1: i_limit = 8'd255;
                    default: i_limit = 8'($urandom_range(1, 30));
                endcase
            end
            clk_step();
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if (cnt[k] !== 8'(m_cnt[k])) begin n_fail++; $display("FAIL random_count d%0d cyc %0d got %0d want %0d", k, c, cnt[k], m_cnt[k]); end
                n_tests++;
                if (tc[k] !== exp_tc(k) || wrap[k] !== m_wrap[k]) begin
                    n_fail++; $display("FAIL random_flags d%0d cyc %0d got tc=%0b wrap=%0b want tc=%0b wrap=%0b", k, c, tc[k], wrap[k], exp_tc(k), m_wrap[k]);
                end
            end
        end
        i_clear = 1'b0; i_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_modulo_down();
        test_saturate();
        test_prescale_enable();
        test_priority();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
